// File: rtl/ram_fifo_dispatch.sv
// ram_fifo_dispatch: drains descriptor-addressed words from the block cache RAM
// into 2**NCH_LOG2 per-output-block FIFOs. Channels are arbitrated round-robin,
// one descriptor at a time, and every RAM read is gated by FIFO credit.
//
// Optional feature: define RAM_FIFO_DISPATCH_STALL_CNT_EN to build a 16-bit
// saturating counter of credit-stall cycles on stall_cnt. When the macro is
// undefined, stall_cnt is tied to zero.
//
// Handshake: a descriptor on channel c transfers on the rising edge where
// desc_valid[c] and desc_ready[c] are both high. desc_ready is combinational,
// at most one bit is set, and only in IDLE. A pending descriptor keeps
// desc_valid high and its fields stable until it is accepted.
module ram_fifo_dispatch #(
  parameter int DATA_WIDTH       = 24,
  parameter int RAM_AW           = 8,
  parameter int NCH_LOG2         = 2,
  parameter int FIFO_DEPTH_WIDTH = 4,
  parameter int RD_LAT           = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [(1<<NCH_LOG2)-1:0]                   desc_valid,
  output logic [(1<<NCH_LOG2)-1:0]                   desc_ready,
  input  logic [(1<<NCH_LOG2)*RAM_AW-1:0]            desc_addr,
  input  logic [(1<<NCH_LOG2)*RAM_AW-1:0]            desc_len,
  output logic                                       ren,
  output logic [RAM_AW-1:0]                          raddr,
  input  logic [DATA_WIDTH-1:0]                      rdata,
  output logic [(1<<NCH_LOG2)-1:0]                   fifo_wrreq,
  output logic [(1<<NCH_LOG2)*DATA_WIDTH-1:0]        fifo_data,
  output logic [(1<<NCH_LOG2)-1:0]                   fifo_wt,
  input  logic [(1<<NCH_LOG2)*(FIFO_DEPTH_WIDTH+1)-1:0] fifo_count,
  output logic                                       addr_finish,
  output logic [NCH_LOG2-1:0]                        finish_ch,
  output logic                                       busy,
  output logic [15:0]                                stall_cnt
);

  localparam int NCH = 1 << NCH_LOG2;
  localparam int CW  = FIFO_DEPTH_WIDTH + 1;
  localparam int CAP = 1 << FIFO_DEPTH_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Arbiter
  logic [NCH_LOG2-1:0] last_grant;
  logic [NCH_LOG2-1:0] gnt_idx;
  logic [NCH_LOG2-1:0] scan_idx;
  logic                gnt_found;
  logic                accept;

  // Active descriptor
  logic [NCH_LOG2-1:0] ch;
  logic [RAM_AW-1:0]   rd_ptr;
  logic [RAM_AW-1:0]   rem;      // words still to read, minus one

  // Credit
  logic [CW-1:0]       pend;
  logic [CW-1:0]       cur_count;
  logic [CW:0]         occupancy;
  logic                credit_ok;
  logic                issue;

  // Read pipeline
  logic                ren_last;
  logic [RD_LAT-1:0]   pipe_v;
  logic [RD_LAT-1:0]   pipe_l;
  logic                pipe_out_v;
  logic                pipe_out_l;
  logic [DATA_WIDTH-1:0] dout;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = last_grant + NCH_LOG2'(i + 1);
      if (!gnt_found && desc_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign accept = (state == IDLE) && gnt_found && !rst;

  // Ready goes to the winning channel only while idle
  always_comb begin
    desc_ready = '0;
    if (accept) begin
      desc_ready[gnt_idx] = 1'b1;
    end
  end

  // Credit: words already in the FIFO plus words in flight must stay below CAP
  assign cur_count = fifo_count[ch*CW +: CW];
  assign occupancy = {1'b0, cur_count} + {1'b0, pend};
  assign credit_ok = occupancy < (CW+1)'(CAP);
  assign issue     = (state == READ) && credit_ok;

  assign pipe_out_v = pipe_v[RD_LAT-1];
  assign pipe_out_l = pipe_l[RD_LAT-1];

  assign busy      = (state != IDLE);
  assign fifo_data = {NCH{dout}};

  // Main FSM: descriptor latch, read issue, drain wait and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= NCH_LOG2'(NCH - 1);
      ch          <= '0;
      rd_ptr      <= '0;
      rem         <= '0;
      ren         <= 1'b0;
      raddr       <= '0;
      ren_last    <= 1'b0;
      addr_finish <= 1'b0;
      finish_ch   <= '0;
    end else begin
      ren         <= 1'b0;
      ren_last    <= 1'b0;
      addr_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ch         <= gnt_idx;
            last_grant <= gnt_idx;
            rd_ptr     <= desc_addr[gnt_idx*RAM_AW +: RAM_AW];
            rem        <= desc_len[gnt_idx*RAM_AW +: RAM_AW];
            state      <= READ;
          end
        end
        READ: begin
          if (issue) begin
            ren      <= 1'b1;
            raddr    <= rd_ptr;
            // Address wraps naturally at 2**RAM_AW
            rd_ptr   <= rd_ptr + RAM_AW'(1);
            ren_last <= (rem == '0);
            if (rem == '0) begin
              state <= DRAIN;
            end else begin
              rem <= rem - RAM_AW'(1);
            end
          end
        end
        DRAIN: begin
          // Once nothing is left in the read path, the word in the output
          // register is the final one and leaves on this edge.
          if (!ren && (pipe_v == '0)) begin
            state       <= DONE;
            addr_finish <= 1'b1;
            finish_ch   <= ch;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Delay line carrying valid/last alongside each outstanding RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      pipe_l <= '0;
    end else begin
      pipe_v[0] <= ren;
      pipe_l[0] <= ren_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
    end
  end

  // Output register: capture returning data and strobe the active lane
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wrreq <= '0;
      fifo_wt    <= '0;
      dout       <= '0;
    end else begin
      fifo_wrreq <= '0;
      fifo_wt    <= '0;
      if (pipe_out_v) begin
        fifo_wrreq[ch] <= 1'b1;
        fifo_wt[ch]    <= pipe_out_l;
        dout           <= rdata;
      end
    end
  end

  // In-flight word count: up on issue, down once fifo_count has absorbed a write
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend + CW'(issue) - CW'(|fifo_wrreq);
    end
  end

`ifdef RAM_FIFO_DISPATCH_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of READ cycles blocked by zero credit
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state == READ) && !credit_ok && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ram_fifo_dispatch.sv
// tb_ram_fifo_dispatch: directed bench for ram_fifo_dispatch. Three instances
// (RD_LAT 1, 2, 3) share one RAM image; instance 0 carries the main scenarios
// and a FIFO occupancy model, instances 1 and 2 join only for the latency sweep.
module tb_ram_fifo_dispatch;

  localparam int DW  = 24;
  localparam int AW  = 8;
  localparam int NL  = 2;
  localparam int NCH = 4;
  localparam int FDW = 4;
  localparam int CW  = FDW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic [NCH-1:0]    desc_valid = '0;
  logic [NCH-1:0]    lat_valid  = '0;
  logic [NCH*AW-1:0] desc_addr  = '0;
  logic [NCH*AW-1:0] desc_len   = '0;
  logic [NCH*CW-1:0] zero_count = '0;

  logic [NCH-1:0]    ready_a [3];
  logic              ren_a   [3];
  logic [AW-1:0]     raddr_a [3];
  logic [DW-1:0]     rdata_a [3];
  logic [NCH-1:0]    wr_a    [3];
  logic [NCH-1:0]    wt_a    [3];
  logic [NCH*DW-1:0] data_a  [3];
  logic              fin_a   [3];
  logic [NL-1:0]     fch_a   [3];
  logic              busy_a  [3];
  logic [15:0]       stall_a [3];

  // ---------------- RAM model ----------------
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {a ^ 8'h5A, ~a, a};
  endfunction

  logic [DW-1:0] rp [3][3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rp[i][0] <= ren_a[i] ? ram_word(raddr_a[i]) : '0;
      rp[i][1] <= rp[i][0];
      rp[i][2] <= rp[i][1];
    end
  end
  assign rdata_a[0] = rp[0][0];
  assign rdata_a[1] = rp[1][1];
  assign rdata_a[2] = rp[2][2];

  // ---------------- FIFO occupancy model (instance 0) ----------------
  logic [CW-1:0]     fc [NCH];
  logic [NCH*CW-1:0] fc_bus;
  logic              fc_ld      = 1'b0;
  logic [NCH-1:0]    fc_ld_mask = '0;
  logic [CW-1:0]     fc_ld_val  = '0;

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) fc[c] <= '0;
      else if (fc_ld && fc_ld_mask[c]) fc[c] <= fc_ld_val;
      else fc[c] <= fc[c] + CW'(wr_a[0][c]);
    end
  end

  always_comb begin
    fc_bus = '0;
    for (int c = 0; c < NCH; c++) fc_bus[c*CW +: CW] = fc[c];
  end

  // ---------------- DUTs ----------------
  ram_fifo_dispatch #(.DATA_WIDTH(DW), .RAM_AW(AW), .NCH_LOG2(NL), .FIFO_DEPTH_WIDTH(FDW), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(ready_a[0]),
    .desc_addr(desc_addr), .desc_len(desc_len), .ren(ren_a[0]), .raddr(raddr_a[0]),
    .rdata(rdata_a[0]), .fifo_wrreq(wr_a[0]), .fifo_data(data_a[0]), .fifo_wt(wt_a[0]),
    .fifo_count(fc_bus), .addr_finish(fin_a[0]), .finish_ch(fch_a[0]), .busy(busy_a[0]),
    .stall_cnt(stall_a[0]));

  ram_fifo_dispatch #(.DATA_WIDTH(DW), .RAM_AW(AW), .NCH_LOG2(NL), .FIFO_DEPTH_WIDTH(FDW), .RD_LAT(2)) u_dut_lat2 (
    .clk(clk), .rst(rst), .desc_valid(lat_valid), .desc_ready(ready_a[1]),
    .desc_addr(desc_addr), .desc_len(desc_len), .ren(ren_a[1]), .raddr(raddr_a[1]),
    .rdata(rdata_a[1]), .fifo_wrreq(wr_a[1]), .fifo_data(data_a[1]), .fifo_wt(wt_a[1]),
    .fifo_count(zero_count), .addr_finish(fin_a[1]), .finish_ch(fch_a[1]), .busy(busy_a[1]),
    .stall_cnt(stall_a[1]));

  ram_fifo_dispatch #(.DATA_WIDTH(DW), .RAM_AW(AW), .NCH_LOG2(NL), .FIFO_DEPTH_WIDTH(FDW), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .desc_valid(lat_valid), .desc_ready(ready_a[2]),
    .desc_addr(desc_addr), .desc_len(desc_len), .ren(ren_a[2]), .raddr(raddr_a[2]),
    .rdata(rdata_a[2]), .fifo_wrreq(wr_a[2]), .fifo_data(data_a[2]), .fifo_wt(wt_a[2]),
    .fifo_count(zero_count), .addr_finish(fin_a[2]), .finish_ch(fch_a[2]), .busy(busy_a[2]),
    .stall_cnt(stall_a[2]));

  // ---------------- event log (instance 0) ----------------
  int            wr_cyc[$], wr_lane[$], wr_wt[$];
  logic [DW-1:0] wr_dat[$];
  int            ren_cyc[$];
  logic [AW-1:0] ren_adr[$];
  int            fin_cyc[$], fin_ch[$], acc_cyc[$], acc_ch[$];
  int            bad_proto = 0;
  int            ovf = 0;

  function automatic int lane_of(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (|wr_a[0]) begin
      wr_cyc.push_back(cyc);
      wr_lane.push_back(lane_of(wr_a[0]));
      wr_wt.push_back(int'(|(wt_a[0] & wr_a[0])));
      wr_dat.push_back(data_a[0][lane_of(wr_a[0])*DW +: DW]);
      if ($countones(wr_a[0]) != 1) bad_proto++;
      if (data_a[0] != {NCH{data_a[0][DW-1:0]}}) bad_proto++;
    end
    if (|(wt_a[0] & ~wr_a[0])) bad_proto++;
    if ($countones(ready_a[0]) > 1) bad_proto++;
    if (ren_a[0]) begin
      ren_cyc.push_back(cyc);
      ren_adr.push_back(raddr_a[0]);
    end
    if (fin_a[0]) begin
      fin_cyc.push_back(cyc);
      fin_ch.push_back(int'(fch_a[0]));
    end
    if (|(desc_valid & ready_a[0])) begin
      acc_cyc.push_back(cyc + 1);
      acc_ch.push_back(lane_of(desc_valid & ready_a[0]));
    end
    for (int c = 0; c < NCH; c++) if (fc[c] > CW'(16)) ovf++;
  end

  // ---------------- latency sweep monitor (all instances) ----------------
  logic sweep_on = 1'b0;
  int   sw_first[3] = '{-1, -1, -1};
  int   sw_cnt[3]   = '{0, 0, 0};
  int   sw_last[3]  = '{0, 0, 0};
  int   sw_bad[3]   = '{0, 0, 0};

  always @(negedge clk) begin
    if (sweep_on) begin
      for (int i = 0; i < 3; i++) begin
        if (|wr_a[i]) begin
          if (sw_cnt[i] == 0) sw_first[i] = cyc;
          else if (cyc != sw_last[i] + 1) sw_bad[i]++;
          if (wr_a[i] != 4'b0001) sw_bad[i]++;
          if (data_a[i][DW-1:0] != ram_word(AW'(8'h80 + sw_cnt[i]))) sw_bad[i]++;
          if (wt_a[i] != ((sw_cnt[i] == 15) ? 4'b0001 : 4'b0000)) sw_bad[i]++;
          sw_last[i] = cyc;
          sw_cnt[i]++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fc_load(input logic [NCH-1:0] mask, input logic [CW-1:0] val);
    @(posedge clk); #1;
    fc_ld = 1'b1; fc_ld_mask = mask; fc_ld_val = val;
    @(posedge clk); #1;
    fc_ld = 1'b0;
  endtask

  task automatic set_desc(input int c, input logic [AW-1:0] a, input logic [AW-1:0] l);
    desc_addr[c*AW +: AW] = a;
    desc_len[c*AW +: AW]  = l;
  endtask

  task automatic send_start(input int c, input logic [AW-1:0] a, input logic [AW-1:0] l, input string tag);
    int n0;
    int budget;
    n0 = acc_cyc.size();
    budget = 60;
    @(posedge clk); #1;
    set_desc(c, a, l);
    desc_valid[c] = 1'b1;
    while (acc_cyc.size() == n0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check(tag, acc_cyc.size() > n0, 1);
    @(posedge clk); #1;
    desc_valid[c] = 1'b0;
  endtask

  task automatic wait_fin(input int n0, input int budget, input string tag);
    int b;
    b = budget;
    while (fin_cyc.size() <= n0 && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    check(tag, fin_cyc.size() > n0, 1);
  endtask

  // ---------------- directed tests ----------------
  int m_w, m_r, m_f, m_a, rst_c, bad, wt_sum, budget;
  int exp_g[5] = '{0, 1, 2, 3, 0};
  logic [AW-1:0] exp_wrap[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {ready_a[0], ren_a[0], raddr_a[0], wr_a[0], wt_a[0], fin_a[0],
                       fch_a[0], busy_a[0], stall_a[0]}, '0);
    check("rst_data", |data_a[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word: ch0 addr 10 len 0
    m_w = wr_cyc.size(); m_r = ren_cyc.size(); m_f = fin_cyc.size(); m_a = acc_cyc.size();
    send_start(0, 8'h10, 8'h00, "t1_accept");
    wait_fin(m_f, 40, "t1_done");
    tick(2);
    check("t1_ren_n",   ren_cyc.size() - m_r, 1);
    check("t1_raddr",   ren_adr[m_r], 8'h10);
    check("t1_ren_lat", ren_cyc[m_r] - acc_cyc[m_a], 1);
    check("t1_wr_n",    wr_cyc.size() - m_w, 1);
    check("t1_wr_lat",  wr_cyc[m_w] - acc_cyc[m_a], 3);
    check("t1_wr_lane", wr_lane[m_w], 0);
    check("t1_wt",      wr_wt[m_w], 1);
    check("t1_data",    wr_dat[m_w], 24'h4AEF10);
    check("t1_fin_lat", fin_cyc[m_f] - acc_cyc[m_a], 4);
    check("t1_fin_ch",  fin_ch[m_f], 0);

    // Wrap: ch2 addr FE len 3
    fc_load(4'b1111, '0);
    m_w = wr_cyc.size(); m_r = ren_cyc.size(); m_f = fin_cyc.size();
    send_start(2, 8'hFE, 8'h03, "t2_accept");
    wait_fin(m_f, 40, "t2_done");
    tick(2);
    check("t2_ren_n", ren_cyc.size() - m_r, 4);
    for (int k = 0; k < 4; k++) check("t2_raddr", ren_adr[m_r + k], exp_wrap[k]);
    check("t2_wr_n",    wr_cyc.size() - m_w, 4);
    check("t2_contig",  wr_cyc[m_w + 3] - wr_cyc[m_w], 3);
    check("t2_wt_pat",  {wr_wt[m_w + 3] != 0, wr_wt[m_w + 2] != 0, wr_wt[m_w + 1] != 0, wr_wt[m_w] != 0}, 4'b1000);
    check("t2_lanes",   (wr_lane[m_w] == 2) && (wr_lane[m_w + 3] == 2), 1);
    check("t2_last_dat", wr_dat[m_w + 3], 24'h5BFE01);
    check("t2_fin_ch",  fin_ch[m_f], 2);

    // Credit stall: ch1 occupancy 14, len 7
    fc_load(4'b1111, '0);
    fc_load(4'b0010, CW'(14));
    m_w = wr_cyc.size(); m_r = ren_cyc.size(); m_f = fin_cyc.size();
    send_start(1, 8'h20, 8'h07, "t3_accept");
    tick(30);
    check("t3_wr_stall",  wr_cyc.size() - m_w, 2);
    check("t3_ren_stall", ren_cyc.size() - m_r, 2);
    check("t3_no_fin",    fin_cyc.size() - m_f, 0);
    check("t3_busy",      busy_a[0], 1);
    fc_load(4'b0010, '0);
    wait_fin(m_f, 60, "t3_done");
    tick(2);
    check("t3_wr_n",  wr_cyc.size() - m_w, 8);
    check("t3_ren_n", ren_cyc.size() - m_r, 8);
    wt_sum = 0;
    for (int k = 0; k < 8; k++) wt_sum += wr_wt[m_w + k];
    check("t3_wt_once", wt_sum, 1);
    check("t3_wt_last", wr_wt[m_w + 7], 1);
    check("t3_last_dat", wr_dat[m_w + 7], 24'h7DD827);
`ifdef RAM_FIFO_DISPATCH_STALL_CNT_EN
    check("t3_stall_cnt", stall_a[0] != 16'd0, 1);
`else
    check("t3_stall_cnt", stall_a[0], 16'd0);
`endif

    // Round-robin: all four channels pending, len 1 each, from reset
    do_reset();
    fc_load(4'b1111, '0);
    for (int c = 0; c < NCH; c++) set_desc(c, AW'(8'h40 + 16 * c), 8'h01);
    m_w = wr_cyc.size(); m_f = fin_cyc.size(); m_a = acc_cyc.size();
    @(posedge clk); #1;
    desc_valid = '1;
    budget = 120;
    while (acc_cyc.size() - m_a < 5 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    @(posedge clk); #1;
    desc_valid = '0;
    check("rr_accepts", acc_cyc.size() - m_a, 5);
    wait_fin(m_f + 4, 60, "rr_done");
    tick(2);
    for (int k = 0; k < 5; k++) check("rr_grant", acc_ch[m_a + k], exp_g[k]);
    check("rr_gap",  acc_cyc[m_a + 1] - acc_cyc[m_a], 7);
    check("rr_wr_n", wr_cyc.size() - m_w, 10);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (wr_lane[m_w + k] != exp_g[k / 2]) bad++;
      if (wr_wt[m_w + k] != (k % 2)) bad++;
    end
    check("rr_lanes_wt", bad, 0);
    check("rr_fin_last", fin_ch[m_f + 4], 0);

    // Latency sweep: RD_LAT 1/2/3, ch0 addr 80 len 15
    fc_load(4'b1111, '0);
    m_a = acc_cyc.size(); m_f = fin_cyc.size();
    @(posedge clk); #1;
    set_desc(0, 8'h80, 8'h0F);
    sweep_on = 1'b1;
    desc_valid[0] = 1'b1;
    lat_valid[0]  = 1'b1;
    budget = 60;
    while (acc_cyc.size() == m_a && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    @(posedge clk); #1;
    desc_valid[0] = 1'b0;
    lat_valid[0]  = 1'b0;
    check("sw_accept", acc_cyc.size() - m_a, 1);
    wait_fin(m_f, 80, "sw_done");
    tick(10);
    sweep_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sw_first_lat", sw_first[i] - acc_cyc[m_a], i + 3);
      check("sw_count",     sw_cnt[i], 16);
      check("sw_errors",    sw_bad[i], 0);
    end

    // Reset during READ: ch3 addr 30 len 9, reset after 3 writes
    fc_load(4'b1111, '0);
    m_w = wr_cyc.size(); m_f = fin_cyc.size();
    send_start(3, 8'h30, 8'h09, "t6_accept");
    budget = 40;
    while (wr_cyc.size() - m_w < 3 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("t6_three_wr", wr_cyc.size() - m_w >= 3, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst_c = cyc;
    @(negedge clk);
    check("t6_rst_ctrl", {ready_a[0], ren_a[0], raddr_a[0], wr_a[0], wt_a[0], fin_a[0],
                          fch_a[0], busy_a[0], stall_a[0]}, '0);
    check("t6_rst_data", |data_a[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(20);
    bad = 0;
    for (int k = m_w; k < wr_cyc.size(); k++) if (wr_cyc[k] >= rst_c) bad++;
    check("t6_no_wr_after", bad, 0);
    check("t6_no_fin", fin_cyc.size() - m_f, 0);
    check("t6_idle", busy_a[0], 0);
    m_w = wr_cyc.size(); m_f = fin_cyc.size();
    send_start(1, 8'h50, 8'h02, "t6_next_accept");
    wait_fin(m_f, 40, "t6_next_done");
    tick(2);
    check("t6_next_wr_n", wr_cyc.size() - m_w, 3);
    check("t6_next_dat",  wr_dat[m_w], 24'h0AAF50);
    check("t6_next_wt",   wr_wt[m_w + 2], 1);
    check("t6_next_ch",   fin_ch[m_f], 1);

    // Global invariants
    check("no_fifo_overflow", ovf, 0);
    check("wr_protocol", bad_proto, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
